// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler for a four-approach intersection with ped crossing.
// Main road rests green; latched requests are served once per round in the order MT, S, PED.
module traffic_phase_scheduler #(
  parameter int CW       = 8,
  parameter int T_MIN_MG = 7,
  parameter int T_Y      = 2,
  parameter int T_AR     = 1,
  parameter int T_TG     = 5,
  parameter int T_MIN_SG = 3,
  parameter int T_MAX_SG = 8,
  parameter int T_PED    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_mt,
  input  logic       req_s,
  input  logic       req_ped,
  input  logic       emg,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic       walk,
  output logic [2:0] grant,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR  = 3'd2,
    TG  = 3'd3,
    TY  = 3'd4,
    SG  = 3'd5,
    SY  = 3'd6,
    PED = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    LS_NONE = 2'd0,
    LS_MT   = 2'd1,
    LS_S    = 2'd2,
    LS_PED  = 2'd3
  } last_t;

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  // Exit thresholds: a phase held N cycles leaves on the edge where timer == N-1.
  localparam logic [CW-1:0] MG_END     = CW'(T_MIN_MG - 1);
  localparam logic [CW-1:0] Y_END      = CW'(T_Y - 1);
  localparam logic [CW-1:0] AR_END     = CW'(T_AR - 1);
  localparam logic [CW-1:0] TG_END     = CW'(T_TG - 1);
  localparam logic [CW-1:0] SG_MIN_END = CW'(T_MIN_SG - 1);
  localparam logic [CW-1:0] SG_MAX_END = CW'(T_MAX_SG - 1);
  localparam logic [CW-1:0] PED_END    = CW'(T_PED - 1);

  state_t        state;
  state_t        nxt;
  last_t         last;
  logic [CW-1:0] timer;
  logic [2:0]    pend;
  logic [2:0]    grant_nxt;
  logic [2:0]    req_vec;

  // Next service after all-red: first pending requester strictly after the last one served.
  function automatic state_t ar_target(input logic [2:0] p, input last_t ls);
    if (p[0] && (ls == LS_NONE)) return TG;
    if (p[1] && ((ls == LS_NONE) || (ls == LS_MT))) return SG;
    if (p[2] && (ls != LS_PED)) return PED;
    return MG;
  endfunction

  // Lamp image {M1, M2, MT, S, walk} shown while in a given state.
  function automatic logic [12:0] lamps(input state_t s);
    case (s)
      MG:      return {LG, LG, LR, LR, 1'b0};
      MY:      return {LY, LY, LR, LR, 1'b0};
      AR:      return {LR, LR, LR, LR, 1'b0};
      TG:      return {LG, LR, LG, LR, 1'b0};
      TY:      return {LY, LR, LY, LR, 1'b0};
      SG:      return {LR, LR, LR, LG, 1'b0};
      SY:      return {LR, LR, LR, LY, 1'b0};
      PED:     return {LR, LR, LR, LR, 1'b1};
      default: return {LR, LR, LR, LR, 1'b0};
    endcase
  endfunction

  assign req_vec = {req_ped, req_s, req_mt};

  always_comb begin
    nxt = state;
    case (state)
      MG:         if (!emg && (|pend) && (timer >= MG_END)) nxt = MY;
      MY, TY, SY: if (timer >= Y_END) nxt = AR;
      TG:         if (emg || (timer >= TG_END)) nxt = TY;
      SG:         if (emg || (timer >= SG_MAX_END) || ((timer >= SG_MIN_END) && !req_s)) nxt = SY;
      PED:        if (emg || (timer >= PED_END)) nxt = AR;
      AR:         if (timer >= AR_END) nxt = emg ? MG : ar_target(pend, last);
      default:    nxt = MG;
    endcase
    grant_nxt = {(nxt == PED) && (state != PED),
                 (nxt == SG)  && (state != SG),
                 (nxt == TG)  && (state != TG)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MG;
      timer    <= '0;
      pend     <= '0;
      last     <= LS_NONE;
      light_M1 <= LG;
      light_M2 <= LG;
      light_MT <= LR;
      light_S  <= LR;
      walk     <= 1'b0;
      grant    <= '0;
      phase    <= 3'd0;
    end else begin
      state <= nxt;
      if (nxt != state) timer <= '0;
      else if (timer != '1) timer <= timer + CW'(1);
      // A request seen while its own grant pulse is out is absorbed by that service.
      pend <= (pend | (req_vec & ~grant)) & ~grant_nxt;
      if ((nxt == MG) && (state != MG)) last <= LS_NONE;
      else if (grant_nxt[0])            last <= LS_MT;
      else if (grant_nxt[1])            last <= LS_S;
      else if (grant_nxt[2])            last <= LS_PED;
      grant <= grant_nxt;
      phase <= nxt;
      {light_M1, light_M2, light_MT, light_S, walk} <= lamps(nxt);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic, checked
// every cycle against a phase/duration reference model of the intersection rules.
module tb_traffic_phase_scheduler;

  localparam int CW       = 8;
  localparam int T_MIN_MG = 7;
  localparam int T_Y      = 2;
  localparam int T_AR     = 1;
  localparam int T_TG     = 5;
  localparam int T_MIN_SG = 3;
  localparam int T_MAX_SG = 8;
  localparam int T_PED    = 6;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_mt = 1'b0, req_s = 1'b0, req_ped = 1'b0, emg = 1'b0;
  logic [2:0] light_M1, light_M2, light_MT, light_S, grant, phase;
  logic       walk;

  traffic_phase_scheduler #(
    .CW(CW), .T_MIN_MG(T_MIN_MG), .T_Y(T_Y), .T_AR(T_AR), .T_TG(T_TG),
    .T_MIN_SG(T_MIN_SG), .T_MAX_SG(T_MAX_SG), .T_PED(T_PED)
  ) dut (
    .clk(clk), .rst(rst), .req_mt(req_mt), .req_s(req_s), .req_ped(req_ped), .emg(emg),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .walk(walk), .grant(grant), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase number, cycles already spent in it, pending set, rank of last service.
  int         m_ph, m_held, m_last;
  logic [2:0] m_pend, m_grant;

  logic [2:0] glog[$];
  int         sg_lens[$];
  int         sg_run, walk_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_held = 0; m_last = -1; m_pend = '0; m_grant = '0;
  endtask

  task automatic model_step(input logic [2:0] req, input logic e);
    int n, k;
    logic [2:0] srv;
    n = m_ph;
    k = m_held + 1;
    case (m_ph)
      0:       if (!e && (m_pend != 0) && k >= T_MIN_MG) n = 1;
      1, 4, 6: if (k >= T_Y) n = 2;
      3:       if (e || k >= T_TG) n = 4;
      5:       if (e || k >= T_MAX_SG || (k >= T_MIN_SG && !req[1])) n = 6;
      7:       if (e || k >= T_PED) n = 2;
      2: if (k >= T_AR) begin
           n = 0;
           if (!e)
             for (int r = 2; r > m_last; r--)
               if (m_pend[r]) n = 3 + 2 * r;
         end
      default: n = 0;
    endcase
    srv = '0;
    if (n != m_ph && (n == 3 || n == 5 || n == 7)) srv[(n - 3) / 2] = 1'b1;
    m_pend = (m_pend | (req & ~m_grant)) & ~srv;
    if (srv != 0) m_last = (n - 3) / 2;
    else if (n == 0 && m_ph != 0) m_last = -1;
    m_held = (n == m_ph) ? k : 0;
    m_ph = n;
    m_grant = srv;
  endtask

  function automatic logic [11:0] lamp_img(input int p);
    case (p)
      0: return {G, G, R, R};
      1: return {Y, Y, R, R};
      3: return {G, R, G, R};
      4: return {Y, R, Y, R};
      5: return {R, R, R, G};
      6: return {R, R, R, Y};
      default: return {R, R, R, R};
    endcase
  endfunction

  function automatic logic [18:0] model_vec();
    logic [2:0] p;
    p = m_ph[2:0];
    return {p, lamp_img(m_ph), (m_ph == 7), m_grant};
  endfunction

  task automatic cycle();
    if (!rst) model_reset();
    else model_step({req_ped, req_s, req_mt}, emg);
    @(posedge clk);
    #1;
    check("outputs", {phase, light_M1, light_M2, light_MT, light_S, walk, grant}, model_vec());
    if (grant != 0) glog.push_back(grant);
    if (walk) walk_cnt++;
    if (phase == 3'd5) sg_run++;
    else if (sg_run != 0) begin
      sg_lens.push_back(sg_run);
      sg_run = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_mt = 1'b0; req_s = 1'b0; req_ped = 1'b0; emg = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    glog.delete();
    sg_lens.delete();
    sg_run = 0;
    walk_cnt = 0;
  endtask

  initial begin
    model_reset();
    sg_run = 0;
    walk_cnt = 0;

    // Asynchronous reset values
    #2 rst = 1'b0;
    #1;
    check("reset_vals", {phase, light_M1, light_M2, light_MT, light_S, walk, grant},
          {3'd0, G, G, R, R, 1'b0, 3'b000});
    cycle();
    cycle();
    rst = 1'b1;

    // Idle: main green rests
    repeat (50) cycle();
    check("idle_no_grant", glog.size(), 0);

    // Single side request pulse at cycle 2
    do_reset();
    cycle();
    cycle();
    req_s = 1'b1;
    cycle();
    req_s = 1'b0;
    repeat (30) cycle();
    check("side_grant_count", glog.size(), 1);
    if (glog.size() == 1) check("side_grant_bit", glog[0], 3'b010);
    check("side_gapout_len", (sg_lens.size() > 0) ? sg_lens[0] : -1, T_MIN_SG);

    // Side extension: req_s held high
    do_reset();
    req_s = 1'b1;
    repeat (40) cycle();
    req_s = 1'b0;
    repeat (60) cycle();
    check("ext_sg_len", (sg_lens.size() > 0) ? sg_lens[0] : -1, T_MAX_SG);
    check("ext_reserved", (glog.size() >= 2 && glog[1] == 3'b010), 1'b1);

    // All three requests in the same MG cycle
    do_reset();
    cycle();
    req_mt = 1'b1; req_s = 1'b1; req_ped = 1'b1;
    cycle();
    req_mt = 1'b0; req_s = 1'b0; req_ped = 1'b0;
    repeat (45) cycle();
    check("all3_count", glog.size(), 3);
    if (glog.size() == 3) begin
      check("all3_first", glog[0], 3'b001);
      check("all3_second", glog[1], 3'b010);
      check("all3_third", glog[2], 3'b100);
    end
    check("all3_walk_len", walk_cnt, T_PED);
    check("all3_back_mg", phase, 3'd0);

    // Emergency during TG cycle 2
    do_reset();
    req_mt = 1'b1;
    cycle();
    req_mt = 1'b0;
    for (int k = 0; k < 30 && phase != 3'd3; k++) cycle();
    check("emg_reach_tg", phase, 3'd3);
    cycle();
    emg = 1'b1;
    req_s = 1'b1;
    cycle();
    req_s = 1'b0;
    check("emg_tg_to_ty", phase, 3'd4);
    repeat (20) cycle();
    check("emg_hold_mg", phase, 3'd0);
    emg = 1'b0;
    repeat (25) cycle();
    check("emg_glog_n", glog.size(), 2);
    if (glog.size() == 2) check("emg_then_side", glog[1], 3'b010);

    // Async reset mid-PED
    do_reset();
    req_ped = 1'b1;
    cycle();
    req_ped = 1'b0;
    for (int k = 0; k < 30 && phase != 3'd7; k++) cycle();
    check("ped_reach", phase, 3'd7);
    cycle();
    req_s = 1'b1;
    cycle();
    req_s = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("rst_walk_drop", walk, 1'b0);
    check("rst_phase_mg", phase, 3'd0);
    check("rst_main_green", {light_M1, light_M2}, {G, G});
    cycle();
    rst = 1'b1;
    glog.delete();
    repeat (30) cycle();
    check("rst_pend_cleared", glog.size(), 0);

    // Random traffic with emergency bursts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_mt  = ($urandom_range(0, 11) == 0);
      req_s   = ($urandom_range(0, 5) == 0);
      req_ped = ($urandom_range(0, 13) == 0);
      if ($urandom_range(0, 59) == 0) emg = ~emg;
      cycle();
    end
    emg = 1'b0;
    req_mt = 1'b0; req_s = 1'b0; req_ped = 1'b0;
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
